// File: rtl/port_wrr_scheduler_if.sv
// Handshake bundle between the per-port queue manager, the scheduler and the read-out datapath.
// The master modport is the scheduler side; the slave modport is the queue manager / datapath side.
interface port_wrr_scheduler_if #(
    parameter int NUM_PRIO = 8
);
    logic [NUM_PRIO-1:0] queue_nonempty;
    logic                ready;
    logic                pkt_done;
    logic                grant_vld;
    logic [2:0]          grant_prio;
    logic                busy;

    modport master (
        input  queue_nonempty,
        input  ready,
        input  pkt_done,
        output grant_vld,
        output grant_prio,
        output busy
    );

    modport slave (
        output queue_nonempty,
        output ready,
        output pkt_done,
        input  grant_vld,
        input  grant_prio,
        input  busy
    );
endinterface

// File: rtl/port_wrr_scheduler.sv
// Per-output-port strict-priority / weighted round-robin packet scheduler.
// Optional per-queue grant counters are built when SCHED_STATS_EN is defined.
module port_wrr_scheduler #(
    parameter int NUM_PRIO = 8,
    parameter int WGT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrr_enable,
    input  logic [NUM_PRIO*WGT_W-1:0] weight_cfg,
`ifdef SCHED_STATS_EN
    input  logic                      stats_clr,
    output logic [NUM_PRIO*16-1:0]    grant_cnt,
`endif
    port_wrr_scheduler_if.master      sched
);

    localparam logic [WGT_W-1:0] WGT_ONE = {{(WGT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               grant_vld_reg, grant_vld_next;
    logic [2:0]         grant_prio_reg, grant_prio_next;
    logic               busy_reg, busy_next;
    logic [WGT_W-1:0]   credit_reg  [NUM_PRIO];
    logic [WGT_W-1:0]   credit_next [NUM_PRIO];
    logic [WGT_W-1:0]   eff_wgt     [NUM_PRIO];
    logic [NUM_PRIO-1:0] eligible;
    logic [2:0]         strict_pick;
    logic [2:0]         wrr_pick;

    // A programmed weight of zero still earns one grant per round so no queue can starve.
    generate
        for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_wgt
            assign eff_wgt[gi]  = (weight_cfg[gi*WGT_W +: WGT_W] == '0) ? WGT_ONE
                                                                       : weight_cfg[gi*WGT_W +: WGT_W];
            assign eligible[gi] = sched.queue_nonempty[gi] && (credit_reg[gi] != '0);
        end
    endgenerate

    function automatic logic [2:0] highest(input logic [NUM_PRIO-1:0] vec);
        highest = 3'd0;
        for (int i = 0; i < NUM_PRIO; i++) begin
            if (vec[i]) begin
                highest = 3'(i);
            end
        end
    endfunction

    assign strict_pick = highest(sched.queue_nonempty);
    assign wrr_pick    = highest(eligible);

    always_comb begin
        state_next      = state_reg;
        grant_vld_next  = 1'b0;
        grant_prio_next = grant_prio_reg;
        busy_next       = busy_reg;
        credit_next     = credit_reg;
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (sched.ready && (|sched.queue_nonempty)) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (!(|sched.queue_nonempty)) begin
                    state_next = IDLE;
                end else begin
                    state_next     = SEND;
                    grant_vld_next = 1'b1;
                    busy_next      = 1'b1;
                    if (!wrr_enable) begin
                        grant_prio_next = strict_pick;
                        credit_next     = eff_wgt;
                    end else if (|eligible) begin
                        grant_prio_next        = wrr_pick;
                        credit_next[wrr_pick]  = credit_reg[wrr_pick] - WGT_ONE;
                    end else begin
                        // Round exhausted: reload every credit and charge this grant to the new round.
                        grant_prio_next          = strict_pick;
                        credit_next              = eff_wgt;
                        credit_next[strict_pick] = eff_wgt[strict_pick] - WGT_ONE;
                    end
                end
            end
            SEND: begin
                if (sched.pkt_done) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_vld_reg  <= 1'b0;
            grant_prio_reg <= 3'd0;
            busy_reg       <= 1'b0;
            credit_reg     <= eff_wgt;
        end else begin
            state_reg      <= state_next;
            grant_vld_reg  <= grant_vld_next;
            grant_prio_reg <= grant_prio_next;
            busy_reg       <= busy_next;
            credit_reg     <= credit_next;
        end
    end

    assign sched.grant_vld  = grant_vld_reg;
    assign sched.grant_prio = grant_prio_reg;
    assign sched.busy       = busy_reg;

`ifdef SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || stats_clr) begin
                    cnt_reg <= 16'd0;
                end else if (grant_vld_reg && (grant_prio_reg == 3'(gi)) && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_port_wrr_scheduler.sv
// Directed self-checking bench for port_wrr_scheduler; covers strict priority, WRR ratio,
// zero weights, grant timing, abort on reset and (with SCHED_STATS_EN) the grant counters.
module tb_port_wrr_scheduler;

    logic        clk;
    logic        rst;
    logic        wrr_enable;
    logic [31:0] weight_cfg;
`ifdef SCHED_STATS_EN
    logic        stats_clr;
    logic [127:0] grant_cnt;
`endif
    int total;
    int bad;

    port_wrr_scheduler_if #(.NUM_PRIO(8)) ifc ();

    port_wrr_scheduler #(.NUM_PRIO(8), .WGT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wrr_enable (wrr_enable),
        .weight_cfg (weight_cfg),
`ifdef SCHED_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt),
`endif
        .sched      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output logic [2:0] p, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        p  = 3'd0;
        for (int k = 0; k < 30 && !ok; k++) begin
            tick();
            n++;
            if (ifc.grant_vld) begin
                ok = 1'b1;
                p  = ifc.grant_prio;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if (ifc.grant_vld !== 1'b0) begin
            bad++; $display("FAIL reset_grant_vld got=%b want=0", ifc.grant_vld);
        end
        total++;
        if (ifc.grant_prio !== 3'd0) begin
            bad++; $display("FAIL reset_grant_prio got=%0d want=0", ifc.grant_prio);
        end
        total++;
        if (ifc.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", ifc.busy);
        end
        rst = 1'b0;
        tick();
        $display("reset: grant_vld=%b grant_prio=%0d busy=%b", ifc.grant_vld, ifc.grant_prio, ifc.busy);
    endtask

    task automatic test_strict();
        logic [2:0] p;
        int n;
        bit ok;
        weight_cfg = 32'h1111_1111;
        wrr_enable = 1'b0;
        do_reset();
        ifc.queue_nonempty = 8'h18;
        ifc.ready = 1'b1;
        ifc.pkt_done = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(p, n, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL strict_timeout grant %0d got=none want=grant", g);
            end
            total++;
            if (p !== 3'd4) begin
                bad++; $display("FAIL strict_prio grant %0d got=%0d want=4", g, p);
            end
            $display("strict grant %0d: prio=%0d", g, p);
            tick();
            total++;
            if (ifc.grant_vld !== 1'b0) begin
                bad++; $display("FAIL strict_pulse got=%b want=0", ifc.grant_vld);
            end
            tick();
            tick();
            total++;
            if (ifc.busy !== 1'b1 || ifc.grant_prio !== 3'd4) begin
                bad++; $display("FAIL strict_hold busy=%b prio=%0d want busy=1 prio=4", ifc.busy, ifc.grant_prio);
            end
            ifc.pkt_done = 1'b1;
            tick();
            ifc.pkt_done = 1'b0;
            total++;
            if (ifc.busy !== 1'b0) begin
                bad++; $display("FAIL strict_done_busy got=%b want=0", ifc.busy);
            end
        end
        ifc.ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrr_ratio();
        logic [2:0] p;
        int n;
        bit ok;
        logic [2:0] exp_seq [8];
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7, 3'd7, 3'd0};
        weight_cfg = 32'h3000_0001;
        wrr_enable = 1'b1;
        ifc.ready = 1'b0;
        do_reset();
        ifc.queue_nonempty = 8'h81;
        ifc.pkt_done = 1'b1;
        ifc.ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            wait_grant(p, n, ok);
            total++;
            if (!ok || p !== exp_seq[g]) begin
                bad++; $display("FAIL wrr_seq grant %0d got=%0d want=%0d", g, p, exp_seq[g]);
            end
            if (g > 0) begin
                total++;
                if (n != 3) begin
                    bad++; $display("FAIL wrr_spacing grant %0d got=%0d cycles want=3", g, n);
                end
            end
            $display("wrr grant %0d: prio=%0d gap=%0d", g, p, n);
        end
        ifc.ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_zero_weight();
        logic [2:0] p;
        int n;
        bit ok;
        weight_cfg = 32'h1111_1011;
        wrr_enable = 1'b1;
        ifc.ready = 1'b0;
        do_reset();
        ifc.queue_nonempty = 8'h04;
        ifc.pkt_done = 1'b1;
        ifc.ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(p, n, ok);
            total++;
            if (!ok || p !== 3'd2) begin
                bad++; $display("FAIL zero_wgt_prio grant %0d got=%0d ok=%b want=2", g, p, ok);
            end
            if (g > 0) begin
                total++;
                if (n != 3) begin
                    bad++; $display("FAIL zero_wgt_spacing grant %0d got=%0d want=3", g, n);
                end
            end
            $display("zero-weight grant %0d: prio=%0d gap=%0d", g, p, n);
        end
        ifc.ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timing();
        wrr_enable = 1'b0;
        weight_cfg = 32'h1111_1111;
        ifc.ready = 1'b0;
        ifc.queue_nonempty = 8'h00;
        ifc.pkt_done = 1'b1;
        do_reset();
        tick();
        ifc.pkt_done = 1'b0;
        ifc.ready = 1'b1;
        ifc.queue_nonempty = 8'h01;
        tick();
        total++;
        if (ifc.grant_vld !== 1'b0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL timing_arb grant_vld=%b busy=%b want 0 0", ifc.grant_vld, ifc.busy);
        end
        ifc.ready = 1'b0;
        tick();
        total++;
        if (ifc.grant_vld !== 1'b1 || ifc.busy !== 1'b1 || ifc.grant_prio !== 3'd0) begin
            bad++; $display("FAIL timing_grant grant_vld=%b busy=%b prio=%0d want 1 1 0",
                            ifc.grant_vld, ifc.busy, ifc.grant_prio);
        end
        ifc.pkt_done = 1'b1;
        tick();
        ifc.pkt_done = 1'b0;
        total++;
        if (ifc.grant_vld !== 1'b0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL timing_done grant_vld=%b busy=%b want 0 0", ifc.grant_vld, ifc.busy);
        end
        $display("timing: grant two cycles after request, idle after same-cycle pkt_done");
        // Queue drains while the scheduler is arbitrating: no grant may be issued.
        ifc.ready = 1'b1;
        ifc.queue_nonempty = 8'h01;
        tick();
        ifc.queue_nonempty = 8'h00;
        tick();
        total++;
        if (ifc.grant_vld !== 1'b0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL empty_arb grant_vld=%b busy=%b want 0 0", ifc.grant_vld, ifc.busy);
        end
        ifc.ready = 1'b0;
        tick();
        $display("empty arb: no grant");
    endtask

    task automatic test_ready_drop();
        logic [2:0] p;
        int n;
        bit ok;
        wrr_enable = 1'b0;
        ifc.pkt_done = 1'b0;
        ifc.queue_nonempty = 8'h20;
        ifc.ready = 1'b1;
        wait_grant(p, n, ok);
        total++;
        if (!ok || p !== 3'd5) begin
            bad++; $display("FAIL drop_grant got=%0d ok=%b want=5", p, ok);
        end
        ifc.ready = 1'b0;
        ifc.queue_nonempty = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (ifc.busy !== 1'b1 || ifc.grant_vld !== 1'b0 || ifc.grant_prio !== 3'd5) begin
                bad++; $display("FAIL drop_hold cycle %0d busy=%b vld=%b prio=%0d want 1 0 5",
                                c, ifc.busy, ifc.grant_vld, ifc.grant_prio);
            end
        end
        ifc.pkt_done = 1'b1;
        tick();
        ifc.pkt_done = 1'b0;
        total++;
        if (ifc.busy !== 1'b0) begin
            bad++; $display("FAIL drop_done busy=%b want=0", ifc.busy);
        end
        $display("ready drop: packet held to completion on prio=%0d", p);
    endtask

    task automatic test_abort();
        logic [2:0] p;
        int n;
        bit ok;
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd0};
        weight_cfg = 32'h3000_0001;
        wrr_enable = 1'b1;
        ifc.ready = 1'b0;
        do_reset();
        ifc.queue_nonempty = 8'h81;
        ifc.pkt_done = 1'b1;
        ifc.ready = 1'b1;
        wait_grant(p, n, ok);
        wait_grant(p, n, ok);
        tick();
        ifc.pkt_done = 1'b0;
        wait_grant(p, n, ok);
        total++;
        if (!ok || p !== 3'd7) begin
            bad++; $display("FAIL abort_pre got=%0d ok=%b want=7", p, ok);
        end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (ifc.busy !== 1'b0 || ifc.grant_vld !== 1'b0 || ifc.grant_prio !== 3'd0) begin
            bad++; $display("FAIL abort_state busy=%b vld=%b prio=%0d want 0 0 0",
                            ifc.busy, ifc.grant_vld, ifc.grant_prio);
        end
        rst = 1'b0;
        ifc.pkt_done = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(p, n, ok);
            total++;
            if (!ok || p !== exp_seq[g]) begin
                bad++; $display("FAIL abort_credit grant %0d got=%0d want=%0d", g, p, exp_seq[g]);
            end
            $display("post-abort grant %0d: prio=%0d", g, p);
        end
        ifc.ready = 1'b0;
        tick();
        tick();
    endtask

`ifdef SCHED_STATS_EN
    task automatic test_stats();
        logic [2:0] p;
        int n;
        bit ok;
        wrr_enable = 1'b0;
        ifc.ready = 1'b0;
        do_reset();
        ifc.queue_nonempty = 8'h08;
        ifc.pkt_done = 1'b1;
        ifc.ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(p, n, ok);
        end
        ifc.ready = 1'b0;
        tick();
        tick();
        total++;
        if (grant_cnt[3*16 +: 16] !== 16'd5) begin
            bad++; $display("FAIL stats_count got=%0d want=5", grant_cnt[3*16 +: 16]);
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        total++;
        if (grant_cnt[3*16 +: 16] !== 16'd0) begin
            bad++; $display("FAIL stats_clear got=%0d want=0", grant_cnt[3*16 +: 16]);
        end
        force dut.g_cnt[3].cnt_reg = 16'hFFFF;
        tick();
        release dut.g_cnt[3].cnt_reg;
        ifc.ready = 1'b1;
        wait_grant(p, n, ok);
        ifc.ready = 1'b0;
        tick();
        tick();
        total++;
        if (grant_cnt[3*16 +: 16] !== 16'hFFFF) begin
            bad++; $display("FAIL stats_saturate got=%h want=ffff", grant_cnt[3*16 +: 16]);
        end
        $display("stats: count/clear/saturate checked on q3");
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        wrr_enable = 1'b0;
        weight_cfg = 32'h1111_1111;
        ifc.queue_nonempty = 8'h00;
        ifc.ready = 1'b0;
        ifc.pkt_done = 1'b0;
`ifdef SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_strict();
        test_wrr_ratio();
        test_zero_weight();
        test_timing();
        test_ready_drop();
        test_abort();
`ifdef SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
